// File: rtl/ram_arb_pkg.sv
// Shared defaults and the in-flight read tracking entry for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_AW   = 6;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned IDW      = $clog2(DEF_NREQ);

  typedef struct packed {
    logic           valid;
    logic           is_read;
    logic [IDW-1:0] id;
  } pipe_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester scanning from ptr upwards, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [IW-1:0]   win_idx_o,
  output logic            found_o
);

  int unsigned cand;
  logic [IW-1:0] ci;
  logic hit;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    hit       = 1'b0;
    cand      = 0;
    ci        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_i) + k) % NREQ;
      ci   = IW'(cand);
      if (!hit && elig_i[ci]) begin
        hit          = 1'b1;
        win_idx_o    = ci;
        win_oh_o[ci] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one RAM port among NREQ requesters; reads return 3 cycles after arbitration.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic             ram_we,
  output logic             ram_rd,
  input  logic [DW-1:0]    ram_q
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d, rd_q, rd_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  pipe_t           pipe1_q, pipe1_d, pipe2_q;

  logic [NREQ-1:0] elig, win_oh;
  logic [IW-1:0]   win_idx;
  logic            found;

  // The requester granted last cycle still holds req for the same command; mask it once.
  assign elig = req & ~gnt_q;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .found_o   (found)
  );

  always_comb begin
    gnt_d   = '0;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    pipe1_d = '0;
    if (found) begin
      gnt_d           = win_oh;
      addr_d          = req_addr[32'(win_idx)*AW +: AW];
      wdata_d         = req_wdata[32'(win_idx)*DW +: DW];
      we_d            = req_we[win_idx];
      rd_d            = ~req_we[win_idx];
      ptr_d           = IW'((32'(win_idx) + 1) % NREQ);
      pipe1_d.valid   = 1'b1;
      pipe1_d.is_read = ~req_we[win_idx];
      pipe1_d.id      = IDW'(win_idx);
    end
  end

  // pipe2 lines up with ram_q of the tracked read; register both into rvalid/rdata.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int unsigned i = 0; i < NREQ; i++)
      rvalid_d[i] = pipe2_q.valid && pipe2_q.is_read && (pipe2_q.id == IDW'(i));
    if (pipe2_q.valid && pipe2_q.is_read)
      rdata_d = ram_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      ptr_q    <= '0;
      pipe1_q  <= '0;
      pipe2_q  <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      ptr_q    <= ptr_d;
      pipe1_q  <= pipe1_d;
      pipe2_q  <= pipe1_q;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign ram_rd    = rd_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a behavioural 64x8 RAM on port A.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0, req_we = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  gnt, rvalid;
  logic [7:0]  rdata, ram_wdata, ram_q;
  logic [5:0]  ram_addr;
  logic        ram_we, ram_rd;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  ram_port_arbiter #(.NREQ(4), .AW(6), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rd    (ram_rd),
    .ram_q     (ram_q)
  );

  typedef struct {
    logic [3:0] rq;
    logic [3:0] we;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [3:0] egnt;
    logic [3:0] erv;
    logic [7:0] erd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] rq, input logic [3:0] we, input logic [5:0] a,
                     input logic [7:0] wd, input logic [3:0] eg, input logic [3:0] ev,
                     input logic [7:0] ed);
    vecs.push_back('{rq, we, a, wd, eg, ev, ed});
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] we, input logic [5:0] a,
                       input logic [7:0] wd);
    req       = rq;
    req_we    = we;
    req_addr  = {4{a}};
    req_wdata = {4{wd}};
  endtask

  initial begin
    logic [5:0] exp_addr;
    logic       ewe, erd;

    //      req      we       addr   wdata   gnt      rvalid   rdata
    add(4'b0001, 4'b0001, 6'd5, 8'hA5, 4'b0001, 4'b0000, 8'h00); // write 5
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b0000, 8'h00); // idle
    add(4'b0001, 4'b0000, 6'd5, 8'h00, 4'b0001, 4'b0000, 8'h00); // read 5
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b0000, 8'h00);
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b0001, 8'hA5);
    add(4'b0010, 4'b0010, 6'd7, 8'h3C, 4'b0010, 4'b0000, 8'h00); // req1 write 7
    add(4'b0100, 4'b0000, 6'd7, 8'h00, 4'b0100, 4'b0000, 8'h00); // req2 read 7 next cycle
    add(4'b0000, 4'b0000, 6'd7, 8'h00, 4'b0000, 4'b0000, 8'h00);
    add(4'b0000, 4'b0000, 6'd7, 8'h00, 4'b0000, 4'b0100, 8'h3C);
    add(4'b1000, 4'b0000, 6'd5, 8'h00, 4'b1000, 4'b0000, 8'h00); // moves ptr to 0
    add(4'b1111, 4'b0000, 6'd5, 8'h00, 4'b0001, 4'b0000, 8'h00); // round robin
    add(4'b1111, 4'b0000, 6'd5, 8'h00, 4'b0010, 4'b1000, 8'hA5);
    add(4'b1111, 4'b0000, 6'd5, 8'h00, 4'b0100, 4'b0001, 8'hA5);
    add(4'b1111, 4'b0000, 6'd5, 8'h00, 4'b1000, 4'b0010, 8'hA5);
    add(4'b1111, 4'b0000, 6'd5, 8'h00, 4'b0001, 4'b0100, 8'hA5); // ptr wrapped 3->0
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b1000, 8'hA5);
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b0001, 8'hA5);
    add(4'b0000, 4'b0000, 6'd5, 8'h00, 4'b0000, 4'b0000, 8'h00);
    add(4'b0100, 4'b0000, 6'd7, 8'h00, 4'b0100, 4'b0000, 8'h00); // lone requester
    add(4'b0100, 4'b0000, 6'd7, 8'h00, 4'b0000, 4'b0000, 8'h00); // masked
    add(4'b0100, 4'b0000, 6'd7, 8'h00, 4'b0100, 4'b0100, 8'h3C);
    add(4'b0000, 4'b0000, 6'd7, 8'h00, 4'b0000, 4'b0000, 8'h00);
    add(4'b0000, 4'b0000, 6'd7, 8'h00, 4'b0000, 4'b0100, 8'h3C);
    add(4'b0001, 4'b0001, 6'd9, 8'h5A, 4'b0001, 4'b0000, 8'h00); // write 9
    add(4'b1010, 4'b0000, 6'd9, 8'h00, 4'b0010, 4'b0000, 8'h00); // req3 loses
    add(4'b0000, 4'b0000, 6'd9, 8'h00, 4'b0000, 4'b0000, 8'h00); // req3 withdrawn
    add(4'b0000, 4'b0000, 6'd9, 8'h00, 4'b0000, 4'b0010, 8'h5A);
    add(4'b0000, 4'b0000, 6'd9, 8'h00, 4'b0000, 4'b0000, 8'h00);

    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_ram_we_rd", {30'd0, ram_we, ram_rd}, 32'h0);
    chk("reset_ram_addr", 32'(ram_addr), 32'h0);
    rst = 1'b0;

    exp_addr = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rq, vecs[i].we, vecs[i].addr, vecs[i].wd);
      @(posedge clk);
      #1;
      ewe = |(vecs[i].egnt & vecs[i].we);
      erd = |(vecs[i].egnt & ~vecs[i].we);
      if (vecs[i].egnt != 4'b0000) exp_addr = vecs[i].addr;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].egnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].erv));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(ewe));
      chk($sformatf("v%0d_ram_rd", i), 32'(ram_rd), 32'(erd));
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(exp_addr));
      if (ewe) chk($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].wd));
      if (vecs[i].erv != 4'b0000) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].erd));
    end

    // Reset lands while a read is one cycle from returning; ptr is 2 beforehand.
    @(negedge clk);
    drive(4'b0010, 4'b0000, 6'd5, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_seq_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 6'd5, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_seq_rvalid_pre", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_rvalid", 32'(rvalid), 32'h0);
    chk("rst_async_rdata", 32'(rdata), 32'h0);
    chk("rst_async_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_async_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_async_ram_we_rd", {30'd0, ram_we, ram_rd}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_after_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    drive(4'b1111, 4'b0000, 6'd5, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_ptr_zero_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 6'd5, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_post_read_rvalid", 32'(rvalid), 32'h1);
    chk("rst_post_read_rdata", 32'(rdata), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
